// File: rtl/gnss_arith_pkg.sv
// Shared arithmetic helpers for the GNSS datapath: slice sizing and a
// packed add-result type for parents that route results as one signal.
package gnss_arith_pkg;

    localparam int unsigned ClaGroupW = 4;
    localparam int unsigned MaxAddW   = 64;

    typedef struct packed {
        logic [MaxAddW-1:0] sum;
        logic               cout;
        logic               ovf;
    } add_res_t;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/cla_4_bit.sv
// 4-bit carry-lookahead adder with group propagate/generate outputs.
module cla_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       pg,
    output logic       gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
        pg   = &p;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/cla_slice.sv
// Combinational W-bit adder: 4-bit lookahead groups linked through their
// group propagate/generate terms.
module cla_slice
    import gnss_arith_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned NGroups = W / ClaGroupW;

    logic [NGroups-1:0] pg;
    logic [NGroups-1:0] gg;
    logic [NGroups:0]   c;

    for (genvar g = 0; g < NGroups; g++) begin : g_grp
        cla_4_bit u_cla (
            .a   (a[g*ClaGroupW +: ClaGroupW]),
            .b   (b[g*ClaGroupW +: ClaGroupW]),
            .cin (c[g]),
            .sum (sum[g*ClaGroupW +: ClaGroupW]),
            .pg  (pg[g]),
            .gg  (gg[g])
        );
    end

    // Group carries depend only on pg/gg, never on a group's own sum.
    always_comb begin
        logic carry;
        carry = cin;
        c[0]  = carry;
        for (int g = 0; g < int'(NGroups); g++) begin
            carry  = gg[g] | (pg[g] & carry);
            c[g+1] = carry;
        end
    end

    assign cout = c[NGroups];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one SLICE_W-bit slice per stage, carry
// registered between stages, valid/ready with bubble-collapsing stall.
module cla_pipe_adder
    import gnss_arith_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SLICE_W = slice_width(WIDTH, STAGES);

    if (WIDTH % STAGES != 0) begin : g_bad_stages
        $error("cla_pipe_adder: WIDTH must be a multiple of STAGES");
    end
    if (SLICE_W % ClaGroupW != 0) begin : g_bad_slice
        $error("cla_pipe_adder: SLICE_W must be a multiple of 4");
    end

    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];

    logic             v_in  [STAGES];
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             adv   [STAGES];

    logic [SLICE_W-1:0] slice_sum  [STAGES];
    logic               slice_cout [STAGES];

    // Ready ripples back from out_ready through the valid chain, no registers.
    always_comb begin
        logic nxt;
        nxt = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            adv[k] = !v_q[k] || nxt;
            nxt    = adv[k];
        end
    end

    always_comb begin
        v_in[0] = in_valid;
        a_in[0] = a;
        b_in[0] = b;
        s_in[0] = '0;
        c_in[0] = cin;
        for (int k = 1; k < int'(STAGES); k++) begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_slice #(
            .W (SLICE_W)
        ) u_slice (
            .a    (a_in[k][k*SLICE_W +: SLICE_W]),
            .b    (b_in[k][k*SLICE_W +: SLICE_W]),
            .cin  (c_in[k]),
            .sum  (slice_sum[k]),
            .cout (slice_cout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            s_nxt[k] = s_in[k];
            s_nxt[k][k*SLICE_W +: SLICE_W] = slice_sum[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_in[k];
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_nxt[k];
                    c_q[k] <= slice_cout[k];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                    && (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule
